// File: rtl/rx_phy_pkg.sv
// Shared RX PHY definitions: lock FSM state encoding, fill threshold, error-source bit map.
// Combinational only; no latency or backpressure.
package rx_phy_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HUNT    = 3'd1,
    FILL    = 3'd2,
    LOCKED  = 3'd3,
    RECOVER = 3'd4
  } rx_state_e;

  // Bit positions in the error-source vector, also read by the receiver status block.
  localparam int ERR_SRC_W      = 4;
  localparam int ERR_BIT_DECODE = 0;
  localparam int ERR_BIT_DISP   = 1;
  localparam int ERR_BIT_OVF    = 2;
  localparam int ERR_BIT_UNF    = 3;

  function automatic int fill_thresh(input int depth);
    return depth / 2;
  endfunction

endpackage

// File: rtl/rx_err_monitor.sv
// Leaky symbol-error counter: +1 per error (saturating), -1 per GOOD_RUN clean symbols.
// Registered count, 1-cycle update; counts only while en is high, no backpressure.
module rx_err_monitor #(
  parameter int ERR_LIMIT = 4,
  parameter int GOOD_RUN  = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           clr,
  input  logic                           en,
  input  logic                           err,
  output logic [$clog2(ERR_LIMIT+1)-1:0] err_cnt,
  output logic                           limit_hit
);

  localparam int EW = $clog2(ERR_LIMIT + 1);
  localparam int GW = $clog2(GOOD_RUN + 1);

  logic [GW-1:0] good_cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      err_cnt  <= '0;
      good_cnt <= '0;
    end else if (en) begin
      if (err) begin
        good_cnt <= '0;
        if (err_cnt != EW'(ERR_LIMIT)) err_cnt <= err_cnt + 1'b1;
      end else if (good_cnt == GW'(GOOD_RUN - 1)) begin
        good_cnt <= '0;
        if (err_cnt != '0) err_cnt <= err_cnt - 1'b1;
      end else begin
        good_cnt <= good_cnt + 1'b1;
      end
    end
  end

  assign limit_hit = (err_cnt == EW'(ERR_LIMIT));

endmodule

// File: rtl/rx_lock_ctrl.sv
// RX bring-up: comma hunt, elastic-buffer prime/flush, RxValid qualification, error-driven relock.
// All outputs registered (1 cycle from decision); read_enable is the only backpressure toward the buffer.
module rx_lock_ctrl
  import rx_phy_pkg::*;
#(
  parameter int BUFFER_DEPTH = 16,
  parameter int LOCK_COMMAS  = 4,
  parameter int COMMA_WINDOW = 64,
  parameter int ERR_LIMIT    = 4,
  parameter int GOOD_RUN     = 16
) (
  input  logic                           CLK,
  input  logic                           Rst,
  input  logic                           rx_enable,
  input  logic                           Comma_pulse,
  input  logic                           DecodeError,
  input  logic                           Disparity_Error,
  input  logic                           Overflow,
  input  logic                           Underflow,
  input  logic [$clog2(BUFFER_DEPTH):0]  buf_level,
  output logic                           read_enable,
  output logic                           buf_flush,
  output logic                           RxValid,
  output logic [2:0]                     lock_state,
  output logic [$clog2(ERR_LIMIT+1)-1:0] err_cnt
);

  localparam int LW = $clog2(BUFFER_DEPTH) + 1;
  localparam int WW = $clog2(COMMA_WINDOW + 1);
  localparam logic [LW-1:0] THRESH = LW'(fill_thresh(BUFFER_DEPTH));

  rx_state_e            state, state_nxt;
  logic [3:0]           comma_cnt;
  logic [WW-1:0]        win_cnt;
  logic [ERR_SRC_W-1:0] err_src;
  logic                 sym_err, buf_fault, lock_hit, limit_hit, mon_en, mon_clr;
  logic                 read_enable_nxt, rx_valid_nxt, buf_flush_nxt;

  assign err_src[ERR_BIT_DECODE] = DecodeError;
  assign err_src[ERR_BIT_DISP]   = Disparity_Error;
  assign err_src[ERR_BIT_OVF]    = Overflow;
  assign err_src[ERR_BIT_UNF]    = Underflow;

  assign sym_err   = err_src[ERR_BIT_DECODE] | err_src[ERR_BIT_DISP];
  assign buf_fault = err_src[ERR_BIT_OVF] | err_src[ERR_BIT_UNF];
  assign lock_hit  = Comma_pulse && (int'(comma_cnt) + 1 >= LOCK_COMMAS);

  always_ff @(posedge CLK) begin
    if (Rst) begin
      state       <= IDLE;
      read_enable <= 1'b0;
      RxValid     <= 1'b0;
      buf_flush   <= 1'b0;
    end else begin
      state       <= state_nxt;
      read_enable <= read_enable_nxt;
      RxValid     <= rx_valid_nxt;
      buf_flush   <= buf_flush_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (rx_enable) state_nxt = HUNT;
      HUNT:    if (lock_hit) state_nxt = FILL;
      FILL:    if (buf_fault) state_nxt = RECOVER;
               else if (buf_level >= THRESH) state_nxt = LOCKED;
      // A buffer fault outranks error-limit relock.
      LOCKED:  if (buf_fault) state_nxt = RECOVER;
               else if (limit_hit) state_nxt = HUNT;
      RECOVER: state_nxt = FILL;
      default: state_nxt = IDLE;
    endcase
    if (!rx_enable) state_nxt = IDLE;
  end

  always_comb begin
    read_enable_nxt = (state_nxt == LOCKED);
    rx_valid_nxt    = (state_nxt == LOCKED);
    buf_flush_nxt   = (state_nxt == RECOVER)
                   || (state == HUNT   && state_nxt == FILL)
                   || (state == LOCKED && state_nxt == HUNT)
                   || ((state == LOCKED || state == FILL) && state_nxt == IDLE);
  end

  // Window counter restarts on each comma; a comma on the expiry cycle still counts.
  always_ff @(posedge CLK) begin
    if (Rst || state != HUNT || state_nxt != HUNT) begin
      comma_cnt <= '0;
      win_cnt   <= '0;
    end else if (Comma_pulse) begin
      comma_cnt <= comma_cnt + 1'b1;
      win_cnt   <= '0;
    end else if (int'(win_cnt) + 1 >= COMMA_WINDOW) begin
      comma_cnt <= '0;
      win_cnt   <= '0;
    end else begin
      win_cnt   <= win_cnt + 1'b1;
    end
  end

  assign mon_en  = (state == LOCKED);
  assign mon_clr = (state_nxt == IDLE) || (state == LOCKED && state_nxt == HUNT);

  rx_err_monitor #(
    .ERR_LIMIT (ERR_LIMIT),
    .GOOD_RUN  (GOOD_RUN)
  ) u_err_mon (
    .clk       (CLK),
    .rst       (Rst),
    .clr       (mon_clr),
    .en        (mon_en),
    .err       (sym_err),
    .err_cnt   (err_cnt),
    .limit_hit (limit_hit)
  );

  assign lock_state = state;

endmodule

// File: tb/tb_rx_lock_ctrl.sv
// Bench for rx_lock_ctrl: vector table, directed corner sequences, then random traffic vs a reference model.
module tb_rx_lock_ctrl;

  localparam int W = 64, LOCKN = 4, ELIM = 4, GRUN = 16, THR = 8;
  localparam int S_IDLE = 0, S_HUNT = 1, S_FILL = 2, S_LOCKED = 3, S_RECOVER = 4;

  logic       CLK = 1'b0;
  logic       rst, en, comma, dec, disp, ovf, unf;
  logic [4:0] lvl;
  logic       read_enable, buf_flush, RxValid;
  logic [2:0] lock_state;
  logic [2:0] err_cnt;

  int n_chk = 0, n_fail = 0;
  int m_state = 0, m_err = 0, m_good = 0, m_commas = 0, m_last = 0, t = 0;
  bit m_re = 0, m_flush = 0;

  typedef struct {
    bit rst, en, comma, dec, ovf;
    int lvl;
    int st;
    bit act, fl;
    int err;
  } vec_t;
  vec_t tbl[16];

  always #2 CLK = ~CLK;

  rx_lock_ctrl dut (
    .CLK(CLK), .Rst(rst), .rx_enable(en), .Comma_pulse(comma),
    .DecodeError(dec), .Disparity_Error(disp), .Overflow(ovf), .Underflow(unf),
    .buf_level(lvl), .read_enable(read_enable), .buf_flush(buf_flush),
    .RxValid(RxValid), .lock_state(lock_state), .err_cnt(err_cnt)
  );

  function automatic vec_t v(bit r, bit e, bit c, bit d, bit o, int l, int s, bit a, bit f, int er);
    vec_t x;
    x.rst = r; x.en = e; x.comma = c; x.dec = d; x.ovf = o; x.lvl = l;
    x.st = s; x.act = a; x.fl = f; x.err = er;
    return x;
  endfunction

  task automatic chk(string name, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Lock progress is the length of the current run of commas whose spacing is <= W cycles.
  task automatic model_step();
    int nxt;
    bit fl, er, flt, limit;
    t++;
    if (rst) begin
      m_state = S_IDLE; m_err = 0; m_good = 0; m_commas = 0; m_re = 0; m_flush = 0;
      return;
    end
    nxt = m_state; fl = 0; er = dec | disp; flt = ovf | unf;
    case (m_state)
      S_IDLE: if (en) begin nxt = S_HUNT; m_commas = 0; end
      S_HUNT: if (comma) begin
        m_commas = (t - m_last <= W) ? m_commas + 1 : 1;
        m_last = t;
        if (m_commas >= LOCKN) begin nxt = S_FILL; fl = 1; end
      end
      S_FILL: if (flt) begin nxt = S_RECOVER; fl = 1; end
              else if (lvl >= THR) nxt = S_LOCKED;
      S_LOCKED: begin
        limit = (m_err == ELIM);
        if (er) begin
          m_err = (m_err < ELIM) ? m_err + 1 : ELIM;
          m_good = 0;
        end else begin
          m_good++;
          if (m_good == GRUN) begin m_good = 0; if (m_err > 0) m_err--; end
        end
        if (flt) begin nxt = S_RECOVER; fl = 1; end
        else if (limit) begin nxt = S_HUNT; fl = 1; m_err = 0; m_good = 0; m_commas = 0; end
      end
      S_RECOVER: nxt = S_FILL;
      default: nxt = S_IDLE;
    endcase
    if (!en) begin
      fl = (m_state == S_LOCKED || m_state == S_FILL);
      nxt = S_IDLE; m_err = 0; m_good = 0; m_commas = 0;
    end
    m_state = nxt; m_re = (nxt == S_LOCKED); m_flush = fl;
  endtask

  task automatic step();
    @(posedge CLK);
    model_step();
    #1;
    chk("lock_state", int'(lock_state), m_state);
    chk("read_enable", int'(read_enable), int'(m_re));
    chk("RxValid", int'(RxValid), int'(m_re));
    chk("buf_flush", int'(buf_flush), int'(m_flush));
    chk("err_cnt", int'(err_cnt), m_err);
    comma = 0; dec = 0; disp = 0; ovf = 0; unf = 0;
  endtask

  task automatic idle(int n);
    repeat (n) step();
  endtask

  task automatic pulse_comma();
    comma = 1;
    step();
  endtask

  task automatic go_hunt();
    rst = 1; en = 0; lvl = 0;
    step();
    rst = 0; en = 1;
    step();
  endtask

  task automatic go_locked();
    go_hunt();
    repeat (LOCKN) pulse_comma();
    lvl = 5'(THR);
    step();
    chk("go_locked.state", int'(lock_state), S_LOCKED);
  endtask

  initial begin
    rst = 1; en = 0; comma = 0; dec = 0; disp = 0; ovf = 0; unf = 0; lvl = 0;

    //           rst en cm dec ovf lvl  st act fl err
    tbl[0]  = v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[1]  = v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[2]  = v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[3]  = v(0, 1, 0, 0, 0, 0, 1, 0, 0, 0);
    tbl[4]  = v(0, 1, 1, 0, 0, 0, 1, 0, 0, 0);
    tbl[5]  = v(0, 1, 1, 0, 0, 0, 1, 0, 0, 0);
    tbl[6]  = v(0, 1, 1, 0, 0, 0, 1, 0, 0, 0);
    tbl[7]  = v(0, 1, 1, 0, 0, 0, 2, 0, 1, 0);
    tbl[8]  = v(0, 1, 0, 0, 0, 7, 2, 0, 0, 0);
    tbl[9]  = v(0, 1, 0, 0, 0, 8, 3, 1, 0, 0);
    tbl[10] = v(0, 1, 0, 1, 0, 8, 3, 1, 0, 1);
    tbl[11] = v(0, 1, 0, 0, 1, 8, 4, 0, 1, 1);
    tbl[12] = v(0, 1, 0, 0, 0, 3, 2, 0, 0, 1);
    tbl[13] = v(0, 1, 0, 0, 0, 9, 3, 1, 0, 1);
    tbl[14] = v(0, 0, 0, 0, 0, 9, 0, 0, 1, 0);
    tbl[15] = v(0, 0, 0, 0, 0, 9, 0, 0, 0, 0);

    for (int i = 0; i < 16; i++) begin
      rst = tbl[i].rst; en = tbl[i].en; comma = tbl[i].comma;
      dec = tbl[i].dec; ovf = tbl[i].ovf; lvl = 5'(tbl[i].lvl);
      step();
      chk($sformatf("vec%0d.state", i), int'(lock_state), tbl[i].st);
      chk($sformatf("vec%0d.read_enable", i), int'(read_enable), int'(tbl[i].act));
      chk($sformatf("vec%0d.RxValid", i), int'(RxValid), int'(tbl[i].act));
      chk($sformatf("vec%0d.buf_flush", i), int'(buf_flush), int'(tbl[i].fl));
      chk($sformatf("vec%0d.err_cnt", i), int'(err_cnt), tbl[i].err);
    end

    // Window timeout: 65-cycle spacing restarts the comma run.
    go_hunt();
    pulse_comma(); idle(19); pulse_comma(); idle(19); pulse_comma();
    chk("win.pre_gap_state", int'(lock_state), S_HUNT);
    idle(64);
    for (int k = 0; k < 3; k++) begin
      pulse_comma();
      chk($sformatf("win.post_gap%0d_state", k), int'(lock_state), S_HUNT);
      idle(9);
    end
    pulse_comma();
    chk("win.lock_state", int'(lock_state), S_FILL);
    chk("win.lock_flush", int'(buf_flush), 1);

    // Spacing of exactly W cycles is still in-window.
    go_hunt();
    pulse_comma(); idle(19); pulse_comma(); idle(19); pulse_comma(); idle(63); pulse_comma();
    chk("win_edge.state", int'(lock_state), S_FILL);

    // Fill threshold ramp.
    for (int l = 0; l < THR; l++) begin
      lvl = 5'(l);
      step();
      chk($sformatf("fill.lvl%0d_re", l), int'(read_enable), 0);
    end
    lvl = 5'(THR);
    step();
    chk("fill.thresh_re", int'(read_enable), 1);
    chk("fill.thresh_valid", int'(RxValid), 1);

    // Error leak then loss of lock.
    go_locked();
    repeat (3) begin dec = 1; step(); end
    chk("leak.err3", int'(err_cnt), 3);
    idle(15);
    chk("leak.err_after15", int'(err_cnt), 3);
    step();
    chk("leak.err_after16", int'(err_cnt), 2);
    repeat (2) begin disp = 1; step(); end
    chk("leak.err4", int'(err_cnt), 4);
    chk("leak.still_valid", int'(RxValid), 1);
    step();
    chk("leak.hunt", int'(lock_state), S_HUNT);
    chk("leak.valid_drop", int'(RxValid), 0);
    chk("leak.flush", int'(buf_flush), 1);
    chk("leak.err_clear", int'(err_cnt), 0);

    // Buffer fault outranks the error that reaches the limit.
    go_locked();
    repeat (3) begin dec = 1; step(); end
    dec = 1; unf = 1; step();
    chk("prio.recover", int'(lock_state), S_RECOVER);
    chk("prio.flush", int'(buf_flush), 1);
    chk("prio.re", int'(read_enable), 0);
    step();
    chk("prio.fill", int'(lock_state), S_FILL);
    chk("prio.err_held", int'(err_cnt), 4);
    chk("prio.flush_once", int'(buf_flush), 0);
    step();
    chk("prio.relock", int'(lock_state), S_LOCKED);
    step();
    chk("prio.limit_hunt", int'(lock_state), S_HUNT);

    // Mid-operation disable and reset.
    go_locked();
    en = 0; step();
    chk("dis.idle", int'(lock_state), S_IDLE);
    chk("dis.flush", int'(buf_flush), 1);
    chk("dis.valid", int'(RxValid), 0);
    step();
    chk("dis.flush_once", int'(buf_flush), 0);
    go_locked();
    rst = 1; step();
    chk("rst.idle", int'(lock_state), S_IDLE);
    chk("rst.flush", int'(buf_flush), 0);
    chk("rst.valid", int'(RxValid), 0);
    chk("rst.re", int'(read_enable), 0);
    rst = 0;

    // Random traffic against the model.
    en = 1;
    for (int i = 0; i < 4000; i++) begin
      rst   = ($urandom_range(0, 599) == 0);
      if (en) en = ($urandom_range(0, 399) != 0);
      else    en = ($urandom_range(0, 7) == 0);
      comma = ($urandom_range(0, 15) == 0);
      dec   = ($urandom_range(0, 23) == 0);
      disp  = ($urandom_range(0, 23) == 0);
      ovf   = ($urandom_range(0, 199) == 0);
      unf   = ($urandom_range(0, 199) == 0);
      lvl   = 5'($urandom_range(0, 16));
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/rx_lock_ctrl.md
Name: rx_lock_ctrl

Overview:
- Sequences RX PHY bring-up after serial-to-parallel conversion: gains symbol lock from comma pulses, primes the elastic buffer, enables its read side and qualifies RxValid.
- Monitors decoder and buffer errors; on persistent errors it drops lock, and on buffer faults it flushes and re-primes the buffer.
- Sits in the 250 MHz decoder/elastic-buffer read domain. It drives read_enable of elasticBuffer and the top-level RxValid.

Parameters:
- BUFFER_DEPTH, 16: elastic buffer depth; the fill threshold is BUFFER_DEPTH/2.
- LOCK_COMMAS, 4: consecutive in-window commas required for lock (range 1..15).
- COMMA_WINDOW, 64: maximum number of cycles between commas while hunting (at least 2).
- ERR_LIMIT, 4: error-counter value that forces loss of lock.
- GOOD_RUN, 16: consecutive clean symbols that decrement the error counter by 1.

Ports:
- CLK  in  1  250 MHz read-domain clock.
- Rst  in  1  reset; synchronous, active-high.
- rx_enable  in  1  link enable; 0 forces IDLE.
- Comma_pulse  in  1  one-cycle K28.5 detect, pre-synchronised into CLK.
- DecodeError  in  1  decoder invalid-symbol flag for the current symbol.
- Disparity_Error  in  1  decoder running-disparity error for the current symbol.
- Overflow  in  1  elastic buffer overflow.
- Underflow  in  1  elastic buffer underflow.
- buf_level  in  $clog2(BUFFER_DEPTH)+1  elastic buffer occupancy.
- read_enable  out  1  elastic buffer read enable.
- buf_flush  out  1  one-cycle buffer pointer reset request.
- RxValid  out  1  symbol lock and data qualified.
- lock_state  out  3  current FSM state encoding (debug/status).
- err_cnt  out  $clog2(ERR_LIMIT+1)  current error-counter value.

Behaviour:
- All outputs are registered. While Rst=1: state=IDLE, read_enable=0, buf_flush=0, RxValid=0, err_cnt=0, and all internal counters are 0. Rst asserted mid-operation takes effect at the next edge, from any state.
- State encodings: IDLE=0, HUNT=1, FILL=2, LOCKED=3, RECOVER=4.
- rx_enable=0 in any state: next state is IDLE and every output returns to its reset value, except that buf_flush pulses for 1 cycle when leaving LOCKED or FILL.
- IDLE: when rx_enable=1, go to HUNT with comma_cnt=0 and win_cnt=0.
- HUNT, counting:
  - win_cnt increments every cycle.
  - On Comma_pulse: comma_cnt increments and win_cnt clears.
  - If win_cnt reaches COMMA_WINDOW with no comma: comma_cnt clears and win_cnt clears.
  - A comma arriving in the same cycle that win_cnt reaches COMMA_WINDOW counts as in-window.
- HUNT, exit: when comma_cnt+1 reaches LOCK_COMMAS on a Comma_pulse, go to FILL and pulse buf_flush for 1 cycle.
- FILL: read_enable=0. When buf_level >= BUFFER_DEPTH/2, go to LOCKED. read_enable and RxValid rise together in the first LOCKED cycle (latency 1 cycle from threshold met).
- LOCKED: read_enable=1 and RxValid=1; each cycle is one symbol.
  - An error is DecodeError OR Disparity_Error; both in one cycle count as one error.
  - On an error: err_cnt increments, saturating at ERR_LIMIT, and good_cnt clears.
  - On a clean cycle: good_cnt increments. When good_cnt reaches GOOD_RUN, err_cnt decrements (floor 0) and good_cnt clears.
  - When err_cnt reaches ERR_LIMIT: go to HUNT on the next cycle. RxValid and read_enable drop, buf_flush pulses, and err_cnt clears.
- Overflow or Underflow in LOCKED or FILL: go to RECOVER. This has priority over error-limit loss of lock in the same cycle.
- RECOVER: lasts exactly 1 cycle. read_enable=0, RxValid=0, buf_flush=1. Next state is FILL. err_cnt is held, not cleared.
- Overflow and Underflow are ignored in IDLE and HUNT.
- Comma_pulse is ignored outside HUNT.

Decomposition:
- Shared package rx_phy_pkg holds:
  - the state enum/localparams IDLE..RECOVER;
  - the FILL_THRESH = BUFFER_DEPTH/2 function;
  - error-source bit positions, shared with Reeceiver_Status.
- One natural sub-module is rx_err_monitor: the err_cnt/good_cnt saturating up/down counter with ERR_LIMIT and GOOD_RUN parameters. It outputs err_cnt and limit_hit and is instantiated once inside LOCKED gating.

Test Plan:
- Reset/enable: Rst=1 for 3 cycles, then rx_enable=1 with 4 Comma_pulses 20 cycles apart -> lock_state 0->1->2, with buf_flush=1 for exactly 1 cycle at FILL entry.
- Window timeout: 3 commas, a 64-cycle gap, then 4 commas 10 cycles apart -> no FILL until the 4th comma after the gap; comma_cnt restarts after the timeout.
- Fill threshold: in FILL, ramp buf_level 0..8 -> read_enable=1 and RxValid=1 exactly 1 cycle after buf_level=8, never at 7.
- Error leak: in LOCKED, inject 3 DecodeErrors, then 16 clean cycles, then 2 Disparity_Errors -> err_cnt goes 3 -> 2 -> 4, then HUNT with RxValid=0 the next cycle.
- Buffer fault priority: in LOCKED with err_cnt=3, assert Underflow together with DecodeError -> state goes to RECOVER (not HUNT) for 1 cycle with buf_flush=1, then FILL with err_cnt=4 held.
- Mid-op disable/reset: in LOCKED, drop rx_enable -> IDLE next cycle with a 1-cycle buf_flush. Repeat with Rst=1 instead -> all outputs 0 and no flush.
